// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded operands/controls and precomputes EX-stage
// operand and store-data forwarding selects; detects load-use hazards and inserts bubbles.

module id_ex_fwd_match (
  input  logic [4:0] src,
  input  logic       uses,
  input  logic       ex_we,
  input  logic [4:0] ex_rd,
  input  logic       wb_we,
  input  logic [4:0] wb_rd,
  output logic       ex_hit,
  output logic       wb_hit
);
  // ex_hit wins: the instruction currently in EX carries the newest value
  assign ex_hit = uses & ex_we & (ex_rd != 5'd0) & (ex_rd == src);
  assign wb_hit = uses & wb_we & (wb_rd != 5'd0) & (wb_rd == src) & ~ex_hit;
endmodule

module id_ex_pipe_reg #(
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ip_stall,
  input  logic              ip_flush,
  input  logic              ip_valid,
  input  logic [31:0]       ip_PC,
  input  logic [31:0]       ip_Data_out1,
  input  logic [31:0]       ip_Data_out2,
  input  logic [31:0]       ip_Imm_Gen,
  input  logic [4:0]        ip_rs1,
  input  logic [4:0]        ip_rs2,
  input  logic [4:0]        ip_rd,
  input  logic              ip_uses_rs1,
  input  logic              ip_uses_rs2,
  input  logic              ip_RegWrite,
  input  logic              ip_MemRead,
  input  logic              ip_MemWrite,
  input  logic [1:0]        ip_ALUSrcA,
  input  logic [1:0]        ip_ALUSrcB,
  input  logic [CTRL_W-1:0] ip_ctrl,
  input  logic [4:0]        ip_EX_MEM_rd,
  input  logic              ip_EX_MEM_RegWrite,
  output logic [31:0]       op_PC,
  output logic [31:0]       op_Data_out1,
  output logic [31:0]       op_Data_out2,
  output logic [31:0]       op_Imm_Gen,
  output logic [4:0]        op_rd,
  output logic              op_RegWrite,
  output logic              op_MemRead,
  output logic              op_MemWrite,
  output logic              op_valid,
  output logic [CTRL_W-1:0] op_ctrl,
  output logic [2:0]        sel_ForwardA,
  output logic [2:0]        sel_ForwardB,
  output logic [1:0]        sel_ForwardS,
  output logic              op_hazard_stall
);
  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       pc;
    logic [31:0]       data1;
    logic [31:0]       data2;
    logic [31:0]       imm;
    logic [2:0]        fwd_a;
    logic [2:0]        fwd_b;
    logic [1:0]        fwd_s;
  } idex_t;

  idex_t idex_q, idex_d;

  logic [NUM_SRC-1:0][4:0] src_idx;
  logic [NUM_SRC-1:0]      src_use;
  logic [NUM_SRC-1:0]      ex_hit;
  logic [NUM_SRC-1:0]      wb_hit;
  logic [2:0]              code_a, code_b;
  logic                    hz;

  assign src_idx = {ip_rs2, ip_rs1};
  assign src_use = {ip_uses_rs2, ip_uses_rs1};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    id_ex_fwd_match u_match (
      .src    (src_idx[g]),
      .uses   (src_use[g]),
      .ex_we  (idex_q.valid & idex_q.reg_write),
      .ex_rd  (idex_q.rd),
      .wb_we  (ip_EX_MEM_RegWrite),
      .wb_rd  (ip_EX_MEM_rd),
      .ex_hit (ex_hit[g]),
      .wb_hit (wb_hit[g])
    );
  end

  // Load in EX whose rd is read by the ID instruction: data not ready until MEM completes
  assign hz = ip_valid & idex_q.valid & idex_q.mem_read & (idex_q.rd != 5'd0) &
              ((ip_uses_rs1 & (ip_rs1 == idex_q.rd)) | (ip_uses_rs2 & (ip_rs2 == idex_q.rd)));
  assign op_hazard_stall = hz & ~ip_flush & ~rst;

  always_comb begin
    code_a = ex_hit[0] ? 3'b110 : (wb_hit[0] ? 3'b101 : 3'b000);
    code_b = ex_hit[1] ? 3'b110 : (wb_hit[1] ? 3'b101 : 3'b000);

    idex_d           = '0;
    idex_d.valid     = ip_valid;
    idex_d.reg_write = ip_RegWrite;
    idex_d.mem_read  = ip_MemRead;
    idex_d.mem_write = ip_MemWrite;
    idex_d.rd        = ip_rd;
    idex_d.ctrl      = ip_ctrl;
    idex_d.pc        = ip_PC;
    idex_d.data1     = ip_Data_out1;
    idex_d.data2     = ip_Data_out2;
    idex_d.imm       = ip_Imm_Gen;

    case (ip_ALUSrcA)
      2'b00:   idex_d.fwd_a = code_a;
      2'b01:   idex_d.fwd_a = 3'b010;
      2'b10:   idex_d.fwd_a = 3'b011;
      default: idex_d.fwd_a = 3'b000;
    endcase

    case (ip_ALUSrcB)
      2'b00:   idex_d.fwd_b = code_b;
      2'b01:   idex_d.fwd_b = 3'b001;
      2'b10:   idex_d.fwd_b = 3'b010;
      default: idex_d.fwd_b = 3'b000;
    endcase

    // Store data follows rs2 regardless of what feeds the ALU's B port
    if (ip_MemWrite) idex_d.fwd_s = {ex_hit[1], wb_hit[1]};
  end

  always_ff @(posedge clk) begin
    if (rst)
      idex_q <= '0;
    else if (!ip_stall) begin
      if (ip_flush || hz) idex_q <= '0;
      else                idex_q <= idex_d;
    end
  end

  assign op_valid     = idex_q.valid;
  assign op_RegWrite  = idex_q.reg_write;
  assign op_MemRead   = idex_q.mem_read;
  assign op_MemWrite  = idex_q.mem_write;
  assign op_rd        = idex_q.rd;
  assign op_ctrl      = idex_q.ctrl;
  assign op_PC        = idex_q.pc;
  assign op_Data_out1 = idex_q.data1;
  assign op_Data_out2 = idex_q.data2;
  assign op_Imm_Gen   = idex_q.imm;
  assign sel_ForwardA = idex_q.fwd_a;
  assign sel_ForwardB = idex_q.fwd_b;
  assign sel_ForwardS = idex_q.fwd_s;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: directed vectors push expected state, a negedge monitor compares.

module tb_id_ex_pipe_reg;
  logic        clk;
  logic        rst, ip_stall, ip_flush, ip_valid;
  logic [31:0] ip_PC, ip_Data_out1, ip_Data_out2, ip_Imm_Gen;
  logic [4:0]  ip_rs1, ip_rs2, ip_rd, ip_EX_MEM_rd;
  logic        ip_uses_rs1, ip_uses_rs2, ip_RegWrite, ip_MemRead, ip_MemWrite, ip_EX_MEM_RegWrite;
  logic [1:0]  ip_ALUSrcA, ip_ALUSrcB;
  logic [7:0]  ip_ctrl;
  logic [31:0] op_PC, op_Data_out1, op_Data_out2, op_Imm_Gen;
  logic [4:0]  op_rd;
  logic        op_RegWrite, op_MemRead, op_MemWrite, op_valid, op_hazard_stall;
  logic [7:0]  op_ctrl;
  logic [2:0]  sel_ForwardA, sel_ForwardB;
  logic [1:0]  sel_ForwardS;

  id_ex_pipe_reg #(.CTRL_W(8)) dut (
    .clk(clk), .rst(rst), .ip_stall(ip_stall), .ip_flush(ip_flush), .ip_valid(ip_valid),
    .ip_PC(ip_PC), .ip_Data_out1(ip_Data_out1), .ip_Data_out2(ip_Data_out2), .ip_Imm_Gen(ip_Imm_Gen),
    .ip_rs1(ip_rs1), .ip_rs2(ip_rs2), .ip_rd(ip_rd), .ip_uses_rs1(ip_uses_rs1), .ip_uses_rs2(ip_uses_rs2),
    .ip_RegWrite(ip_RegWrite), .ip_MemRead(ip_MemRead), .ip_MemWrite(ip_MemWrite),
    .ip_ALUSrcA(ip_ALUSrcA), .ip_ALUSrcB(ip_ALUSrcB), .ip_ctrl(ip_ctrl),
    .ip_EX_MEM_rd(ip_EX_MEM_rd), .ip_EX_MEM_RegWrite(ip_EX_MEM_RegWrite),
    .op_PC(op_PC), .op_Data_out1(op_Data_out1), .op_Data_out2(op_Data_out2), .op_Imm_Gen(op_Imm_Gen),
    .op_rd(op_rd), .op_RegWrite(op_RegWrite), .op_MemRead(op_MemRead), .op_MemWrite(op_MemWrite),
    .op_valid(op_valid), .op_ctrl(op_ctrl), .sel_ForwardA(sel_ForwardA), .sel_ForwardB(sel_ForwardB),
    .sel_ForwardS(sel_ForwardS), .op_hazard_stall(op_hazard_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic valid, rw, mr, mw;
    logic [4:0] rd;
    logic [2:0] fa, fb;
    logic [1:0] fs;
    logic [31:0] pc, d1, d2, imm;
    logic [7:0] ctrl;
  } obs_t;

  typedef struct packed {
    logic rst, stall, flush, valid;
    logic [4:0] rd, rs1, rs2;
    logic u1, u2, rw, mr, mw;
    logic [1:0] sa, sb;
    logic [4:0] xrd;
    logic xrw;
  } vin_t;

  typedef struct {
    int   n;
    logic hz;
    obs_t o;
  } item_t;

  localparam int LD = 0, BUB = 1, HOLD = 2;

  item_t q[$];
  obs_t  exp_st;
  obs_t  act;
  int    checks = 0;
  int    failures = 0;

  assign act = {op_valid, op_RegWrite, op_MemRead, op_MemWrite, op_rd, sel_ForwardA, sel_ForwardB,
                sel_ForwardS, op_PC, op_Data_out1, op_Data_out2, op_Imm_Gen, op_ctrl};

  function automatic vin_t mkv(logic r, logic st, logic fl, logic v,
                               logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                               logic u1, logic u2, logic rw, logic mr, logic mw,
                               logic [1:0] sa, logic [1:0] sb, logic [4:0] xrd, logic xrw);
    vin_t x;
    x = '{r, st, fl, v, rd, rs1, rs2, u1, u2, rw, mr, mw, sa, sb, xrd, xrw};
    return x;
  endfunction

  // Applies vector n just after a rising edge; the queued item describes what the monitor
  // must see at the following falling edge: state from the previous edge plus this vector's stall.
  task automatic step(input int n, input vin_t v, input int kind,
                      input logic [2:0] fa, input logic [2:0] fb, input logic [1:0] fs, input logic hz);
    item_t it;
    rst = v.rst; ip_stall = v.stall; ip_flush = v.flush; ip_valid = v.valid;
    ip_rd = v.rd; ip_rs1 = v.rs1; ip_rs2 = v.rs2; ip_uses_rs1 = v.u1; ip_uses_rs2 = v.u2;
    ip_RegWrite = v.rw; ip_MemRead = v.mr; ip_MemWrite = v.mw;
    ip_ALUSrcA = v.sa; ip_ALUSrcB = v.sb; ip_EX_MEM_rd = v.xrd; ip_EX_MEM_RegWrite = v.xrw;
    ip_PC = 32'h1000 + 32'(n) * 4;
    ip_Data_out1 = 32'hA000_0000 + 32'(n);
    ip_Data_out2 = 32'hB000_0000 + 32'(n);
    ip_Imm_Gen = 32'(n) * 8;
    ip_ctrl = 8'(n + 1);
    it.n = n; it.hz = hz; it.o = exp_st;
    q.push_back(it);
    case (kind)
      LD:  exp_st = '{v.valid, v.rw, v.mr, v.mw, v.rd, fa, fb, fs,
                      32'h1000 + 32'(n) * 4, 32'hA000_0000 + 32'(n), 32'hB000_0000 + 32'(n),
                      32'(n) * 8, 8'(n + 1)};
      BUB: exp_st = '0;
      default: ;
    endcase
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it = q.pop_front();
        checks++;
        if (act !== it.o) begin
          failures++;
          $display("FAIL state v%0d: got %h expected %h", it.n, act, it.o);
        end
        checks++;
        if (op_hazard_stall !== it.hz) begin
          failures++;
          $display("FAIL hazard_stall v%0d: got %b expected %b", it.n, op_hazard_stall, it.hz);
        end
      end
    end
  end

  initial begin : driver
    exp_st = '0;
    rst = 1'b1; ip_stall = 0; ip_flush = 0; ip_valid = 0;
    ip_rd = 0; ip_rs1 = 0; ip_rs2 = 0; ip_uses_rs1 = 0; ip_uses_rs2 = 0;
    ip_RegWrite = 0; ip_MemRead = 0; ip_MemWrite = 0; ip_ALUSrcA = 0; ip_ALUSrcB = 0;
    ip_EX_MEM_rd = 0; ip_EX_MEM_RegWrite = 0; ip_PC = 0; ip_Data_out1 = 0; ip_Data_out2 = 0;
    ip_Imm_Gen = 0; ip_ctrl = 0;
    @(posedge clk); #1;
    //         rst st fl v  rd rs1 rs2 u1 u2 rw mr mw sa sb xrd xrw
    step(0,  mkv(1, 0, 0, 1, 5,  1,  2, 1, 1, 1, 0, 0, 0, 0, 0, 0), BUB, 3'b000, 3'b000, 2'b00, 0);
    step(1,  mkv(1, 0, 0, 1, 5,  1,  2, 1, 1, 1, 0, 0, 0, 0, 0, 0), BUB, 3'b000, 3'b000, 2'b00, 0);
    step(2,  mkv(0, 0, 0, 1, 5,  1,  2, 1, 1, 1, 0, 0, 0, 0, 0, 0), LD,  3'b000, 3'b000, 2'b00, 0);
    step(3,  mkv(0, 0, 0, 1, 6,  5,  3, 1, 1, 1, 0, 0, 0, 0, 0, 0), LD,  3'b110, 3'b000, 2'b00, 0);
    step(4,  mkv(0, 0, 0, 1, 5,  1,  0, 1, 0, 1, 1, 0, 0, 1, 5, 1), LD,  3'b000, 3'b001, 2'b00, 0);
    step(5,  mkv(0, 0, 0, 1, 6,  5,  5, 1, 1, 1, 0, 0, 0, 0, 6, 1), BUB, 3'b000, 3'b000, 2'b00, 1);
    step(6,  mkv(0, 0, 0, 1, 6,  5,  5, 1, 1, 1, 0, 0, 0, 0, 5, 1), LD,  3'b101, 3'b101, 2'b00, 0);
    step(7,  mkv(0, 0, 0, 1, 5,  1,  2, 1, 1, 1, 0, 0, 0, 0, 0, 0), LD,  3'b000, 3'b000, 2'b00, 0);
    step(8,  mkv(0, 0, 0, 1, 0,  2,  5, 1, 1, 0, 0, 1, 0, 1, 2, 1), LD,  3'b101, 3'b001, 2'b10, 0);
    step(9,  mkv(0, 0, 0, 1, 0,  1,  2, 1, 1, 1, 0, 0, 1, 2, 0, 1), LD,  3'b010, 3'b010, 2'b00, 0);
    step(10, mkv(0, 0, 0, 1, 7,  0,  0, 1, 1, 1, 0, 0, 0, 0, 0, 1), LD,  3'b000, 3'b000, 2'b00, 0);
    step(11, mkv(0, 0, 0, 1, 8,  7,  7, 0, 0, 1, 0, 0, 0, 0, 0, 0), LD,  3'b000, 3'b000, 2'b00, 0);
    step(12, mkv(0, 0, 0, 1, 9,  8,  0, 0, 0, 1, 0, 0, 2, 1, 0, 0), LD,  3'b011, 3'b001, 2'b00, 0);
    step(13, mkv(0, 0, 0, 1, 0,  9,  9, 1, 1, 0, 0, 1, 3, 3, 0, 0), LD,  3'b000, 3'b000, 2'b10, 0);
    step(14, mkv(0, 0, 0, 1, 10, 3,  0, 1, 0, 1, 0, 0, 0, 2, 3, 1), LD,  3'b101, 3'b010, 2'b00, 0);
    step(15, mkv(0, 0, 0, 1, 11, 10, 10, 1, 1, 1, 0, 0, 0, 0, 10, 1), LD, 3'b110, 3'b110, 2'b00, 0);
    for (int i = 16; i < 19; i++)
      step(i, mkv(0, 1, 0, 1, 12, 11, 11, 1, 1, 1, 0, 0, 0, 0, 0, 0), HOLD, 3'b000, 3'b000, 2'b00, 0);
    step(19, mkv(0, 0, 1, 1, 12, 11, 11, 1, 1, 1, 0, 0, 0, 0, 0, 0), BUB, 3'b000, 3'b000, 2'b00, 0);
    step(20, mkv(0, 0, 0, 1, 13, 1,  0, 1, 0, 1, 1, 0, 0, 1, 0, 0), LD,  3'b000, 3'b001, 2'b00, 0);
    step(21, mkv(0, 0, 1, 1, 14, 13, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0), BUB, 3'b000, 3'b000, 2'b00, 0);
    step(22, mkv(0, 0, 0, 1, 13, 1,  0, 1, 0, 1, 1, 0, 0, 1, 0, 0), LD,  3'b000, 3'b001, 2'b00, 0);
    step(23, mkv(0, 1, 0, 1, 14, 13, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0), HOLD, 3'b000, 3'b000, 2'b00, 1);
    step(24, mkv(0, 0, 0, 1, 14, 13, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0), BUB, 3'b000, 3'b000, 2'b00, 1);
    step(25, mkv(0, 0, 0, 1, 14, 13, 2, 1, 1, 1, 0, 0, 0, 0, 13, 1), LD, 3'b101, 3'b000, 2'b00, 0);
    step(26, mkv(1, 0, 0, 1, 15, 14, 14, 1, 1, 1, 0, 0, 0, 0, 0, 0), BUB, 3'b000, 3'b000, 2'b00, 0);
    step(27, mkv(0, 0, 0, 1, 16, 1,  2, 1, 1, 1, 0, 0, 0, 0, 0, 0), LD,  3'b000, 3'b000, 2'b00, 0);
    step(28, mkv(1, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0), BUB, 3'b000, 3'b000, 2'b00, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending items, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
